// File: rtl/seg_arb_pkg.sv
// Shared constants and state encoding for the seven-segment display arbiter.
package seg_arb_pkg;

    localparam int BCD_W = 16;
    localparam logic [BCD_W-1:0] BLANK_CODE = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester at or after i_start,
// scanning upward with wrap-around.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [IDX_W-1:0]   o_idx
);

    // Descending scan so the closest candidate to i_start is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            o_found = o_found | i_req[(int'(i_start) + k) % NUM_SRC];
            o_idx   = i_req[(int'(i_start) + k) % NUM_SRC]
                    ? IDX_W'((int'(i_start) + k) % NUM_SRC) : o_idx;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of one 4-digit BCD display among NUM_SRC requesters.
// Optional macro SEG_ARB_PREEMPT_EN makes source 0 a preempting alert source.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 1024,
    localparam int IDX_W       = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [BCD_W*NUM_SRC-1:0]   src_bcd,
    output logic [NUM_SRC-1:0]         grant,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       active,
    output logic [BCD_W-1:0]           bcd_out
);

    localparam int              CNT_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_active;
    logic [NUM_SRC-1:0]   r_grant;
    logic [BCD_W-1:0]     r_bcd;

    state_t               w_nx_state;
    logic [IDX_W-1:0]     w_nx_idx;
    logic [IDX_W-1:0]     w_nx_ptr;
    logic [CNT_W-1:0]     w_nx_cnt;
    logic                 w_nx_active;
    logic [NUM_SRC-1:0]   w_nx_grant;
    logic [BCD_W-1:0]     w_nx_bcd;

    logic [IDX_W-1:0]     w_after;
    logic                 w_cur_req;
    logic                 w_others;
    logic                 w_ptr_found;
    logic [IDX_W-1:0]     w_ptr_idx;
    logic                 w_nxt_found;
    logic [IDX_W-1:0]     w_nxt_idx;
    logic                 w_rel_found;
    logic [IDX_W-1:0]     w_rel_idx;

    assign w_after   = (r_idx == IDX_W'(NUM_SRC - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_cur_req = req[r_idx];
    assign w_others  = |(req & ~(NUM_SRC'(1) << r_idx));

    rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick_ptr (
        .i_req   (req),
        .i_start (r_ptr),
        .o_found (w_ptr_found),
        .o_idx   (w_ptr_idx)
    );

    rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_pick_next (
        .i_req   (req),
        .i_start (w_after),
        .o_found (w_nxt_found),
        .o_idx   (w_nxt_idx)
    );

    // Successor on release; an alert release resumes from the untouched pointer.
    always_comb begin
`ifdef SEG_ARB_PREEMPT_EN
        if (r_idx == '0) begin
            w_rel_found = w_ptr_found;
            w_rel_idx   = w_ptr_idx;
        end else begin
            w_rel_found = w_nxt_found;
            w_rel_idx   = w_nxt_idx;
        end
`else
        w_rel_found = w_nxt_found;
        w_rel_idx   = w_nxt_idx;
`endif
    end

    // Next-state, grant and dwell logic; release takes priority over expiry.
    always_comb begin
        w_nx_state  = r_state;
        w_nx_idx    = r_idx;
        w_nx_ptr    = r_ptr;
        w_nx_cnt    = r_cnt;
        w_nx_active = r_active;
        case (r_state)
            IDLE: begin
                w_nx_cnt = '0;
                if (w_ptr_found) begin
                    w_nx_state  = SHOW;
                    w_nx_idx    = w_ptr_idx;
                    w_nx_active = 1'b1;
                end else begin
                    w_nx_idx    = '0;
                    w_nx_active = 1'b0;
                end
            end
            SHOW: begin
                w_nx_active = 1'b1;
                if (!w_cur_req) begin
                    w_nx_cnt = '0;
                    if (w_rel_found) begin
                        w_nx_idx = w_rel_idx;
                    end else begin
                        w_nx_state  = IDLE;
                        w_nx_idx    = '0;
                        w_nx_active = 1'b0;
                    end
                end
`ifdef SEG_ARB_PREEMPT_EN
                else if (req[0] && (r_idx != '0)) begin
                    w_nx_idx = '0;
                    w_nx_cnt = '0;
                end else if (r_idx == '0) begin
                    w_nx_cnt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                end
`endif
                else if (r_cnt == CNT_MAX) begin
                    if (w_others) begin
                        w_nx_idx = w_nxt_idx;
                        w_nx_cnt = '0;
                        w_nx_ptr = w_after;
                    end else begin
                        w_nx_cnt = r_cnt;
                    end
                end else begin
                    w_nx_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nx_state  = IDLE;
                w_nx_idx    = '0;
                w_nx_ptr    = '0;
                w_nx_cnt    = '0;
                w_nx_active = 1'b0;
            end
        endcase
    end

    // Output words for the coming cycle, taken from the live source slice.
    always_comb begin
        if (w_nx_active) begin
            w_nx_grant = NUM_SRC'(1) << w_nx_idx;
            w_nx_bcd   = src_bcd[int'(w_nx_idx) * BCD_W +: BCD_W];
        end else begin
            w_nx_grant = '0;
            w_nx_bcd   = BLANK_CODE;
        end
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_grant  <= '0;
            r_bcd    <= BLANK_CODE;
        end else begin
            r_state  <= w_nx_state;
            r_idx    <= w_nx_idx;
            r_ptr    <= w_nx_ptr;
            r_cnt    <= w_nx_cnt;
            r_active <= w_nx_active;
            r_grant  <= w_nx_grant;
            r_bcd    <= w_nx_bcd;
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_idx;
    assign active    = r_active;
    assign bcd_out   = r_bcd;

endmodule
